// File: rtl/mreg_bank_pkg.sv
// Shared constants, response encoding and the saturating error-count helper
// for the mreg_bank register block.
package mreg_bank_pkg;

  localparam int DATA_WIDTH    = 32;
  localparam int ERR_CNT_WIDTH = 8;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_ACK  = 2'd1,
    RSP_ERR  = 2'd2
  } rsp_e;

  function automatic logic [ERR_CNT_WIDTH-1:0] sat_add(
    input logic [ERR_CNT_WIDTH-1:0] cnt,
    input logic [1:0]               inc
  );
    logic [ERR_CNT_WIDTH:0] sum;
    sum = {1'b0, cnt} + {{(ERR_CNT_WIDTH-1){1'b0}}, inc};
    if (sum[ERR_CNT_WIDTH]) begin
      sat_add = {ERR_CNT_WIDTH{1'b1}};
    end else begin
      sat_add = sum[ERR_CNT_WIDTH-1:0];
    end
  endfunction

endpackage

// File: rtl/mreg_bank_reg.sv
// One bank register: loads on its write enable and answers with a one-cycle
// strobe and write acknowledge in the cycle the new value becomes visible.
module mreg_bank_reg
  import mreg_bank_pkg::*;
#(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] value,
  output logic             strobe,
  output logic             wack
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value  <= RESET_VAL;
      strobe <= 1'b0;
      wack   <= 1'b0;
    end else begin
      strobe <= wr_en;
      wack   <= wr_en;
      if (wr_en) begin
        value <= wr_data;
      end
    end
  end

endmodule

// File: rtl/mreg_bank.sv
// mreg_bank: VME word-mapped register bank; write ack two edges after the
// request, read ack one edge after. Define MREG_BANK_RD_PIPE_EN for a 2-cycle read.
module mreg_bank
  import mreg_bank_pkg::*;
#(
  parameter int                          N_REGS     = 4,
  parameter int                          REG_WIDTH  = 16,
  parameter int                          ADDR_WIDTH = 18,
  parameter logic [N_REGS*REG_WIDTH-1:0] RESET_VAL  = '0
) (
  input  logic                          Clk,
  input  logic                          Rst,
  input  logic [ADDR_WIDTH-1:0]         VMEAddr,
  output logic [DATA_WIDTH-1:0]         VMERdData,
  input  logic [DATA_WIDTH-1:0]         VMEWrData,
  input  logic                          VMERdMem,
  input  logic                          VMEWrMem,
  output logic                          VMERdDone,
  output logic                          VMEWrDone,
  output logic                          VMERdError,
  output logic                          VMEWrError,
  output logic [N_REGS*REG_WIDTH-1:0]   regs_o,
  output logic [N_REGS-1:0]             wr_strobe_o,
  output logic [ERR_CNT_WIDTH-1:0]      err_cnt_o
);

  localparam logic [ADDR_WIDTH:0] N_REGS_A = (ADDR_WIDTH+1)'(N_REGS);

  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [REG_WIDTH-1:0]  wr_data;
  logic                  wr_err;
  logic                  wr_mapped;
  logic [N_REGS-1:0]     wr_en;
  logic [N_REGS-1:0]     wack;
  logic [REG_WIDTH-1:0]  reg_val [N_REGS];

  logic                  rd_mapped;
  logic [REG_WIDTH-1:0]  rd_word;
  rsp_e                  rd_rsp;
  logic [DATA_WIDTH-1:0] rd_data;
  rsp_e                  out_rsp;

  // Upper write-data bits above REG_WIDTH are intentionally dropped.
  logic unused_wr_bits;
  assign unused_wr_bits = ^VMEWrData;

  assign wr_mapped = ({1'b0, wr_addr} < N_REGS_A);
  assign rd_mapped = ({1'b0, VMEAddr} < N_REGS_A);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_req  <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_err  <= 1'b0;
    end else begin
      wr_req  <= VMEWrMem;
      wr_addr <= VMEAddr;
      wr_data <= VMEWrData[REG_WIDTH-1:0];
      wr_err  <= wr_req & ~wr_mapped;
    end
  end

  for (genvar i = 0; i < N_REGS; i++) begin : g_reg
    assign wr_en[i] = wr_req && (wr_addr == ADDR_WIDTH'(i));

    mreg_bank_reg #(
      .WIDTH     (REG_WIDTH),
      .RESET_VAL (RESET_VAL[i*REG_WIDTH +: REG_WIDTH])
    ) u_reg (
      .clk     (Clk),
      .rst     (Rst),
      .wr_en   (wr_en[i]),
      .wr_data (wr_data),
      .value   (reg_val[i]),
      .strobe  (wr_strobe_o[i]),
      .wack    (wack[i])
    );

    assign regs_o[i*REG_WIDTH +: REG_WIDTH] = reg_val[i];
  end

  assign VMEWrDone  = |wack;
  assign VMEWrError = wr_err;

  // One-hot OR mux: unmapped addresses select nothing and yield zero.
  always_comb begin
    rd_word = '0;
    for (int i = 0; i < N_REGS; i++) begin
      rd_word = rd_word | (reg_val[i] & {REG_WIDTH{VMEAddr == ADDR_WIDTH'(i)}});
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_rsp  <= RSP_NONE;
      rd_data <= '0;
    end else if (VMERdMem) begin
      if (rd_mapped) begin
        rd_rsp  <= RSP_ACK;
        rd_data <= DATA_WIDTH'(rd_word);
      end else begin
        rd_rsp  <= RSP_ERR;
        rd_data <= '0;
      end
    end else begin
      rd_rsp <= RSP_NONE;
    end
  end

`ifdef MREG_BANK_RD_PIPE_EN
  rsp_e                  rd_rsp_p;
  logic [DATA_WIDTH-1:0] rd_data_p;

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_rsp_p  <= RSP_NONE;
      rd_data_p <= '0;
    end else begin
      rd_rsp_p  <= rd_rsp;
      rd_data_p <= rd_data;
    end
  end

  assign out_rsp   = rd_rsp_p;
  assign VMERdData = rd_data_p;
`else
  assign out_rsp   = rd_rsp;
  assign VMERdData = rd_data;
`endif

  assign VMERdDone  = (out_rsp == RSP_ACK);
  assign VMERdError = (out_rsp == RSP_ERR);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      err_cnt_o <= '0;
    end else begin
      err_cnt_o <= sat_add(err_cnt_o, {1'b0, VMERdError} + {1'b0, VMEWrError});
    end
  end

endmodule

// File: tb/tb_mreg_bank.sv
// Directed bench for mreg_bank with a cycle-indexed event model of expected
// acks, errors, strobes, register image, read data and error count.
module tb_mreg_bank;

  localparam int          NR    = 4;
  localparam int          RW    = 16;
  localparam int          AW    = 18;
  localparam int          DEPTH = 2048;
  localparam logic [63:0] RV    = 64'h4444_3333_0001_A5A5;
`ifdef MREG_BANK_RD_PIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic          Clk = 1'b0;
  logic          Rst = 1'b1;
  logic [AW-1:0] VMEAddr;
  logic [31:0]   VMERdData;
  logic [31:0]   VMEWrData;
  logic          VMERdMem;
  logic          VMEWrMem;
  logic          VMERdDone;
  logic          VMEWrDone;
  logic          VMERdError;
  logic          VMEWrError;
  logic [63:0]   regs_o;
  logic [3:0]    wr_strobe_o;
  logic [7:0]    err_cnt_o;

  mreg_bank #(
    .N_REGS     (NR),
    .REG_WIDTH  (RW),
    .ADDR_WIDTH (AW),
    .RESET_VAL  (RV)
  ) dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .VMEAddr     (VMEAddr),
    .VMERdData   (VMERdData),
    .VMEWrData   (VMEWrData),
    .VMERdMem    (VMERdMem),
    .VMEWrMem    (VMEWrMem),
    .VMERdDone   (VMERdDone),
    .VMEWrDone   (VMEWrDone),
    .VMERdError  (VMERdError),
    .VMEWrError  (VMEWrError),
    .regs_o      (regs_o),
    .wr_strobe_o (wr_strobe_o),
    .err_cnt_o   (err_cnt_o)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected events, indexed by the cycle in which they must be visible.
  bit          exp_wd  [DEPTH];
  bit          exp_we  [DEPTH];
  bit          exp_rd  [DEPTH];
  bit          exp_re  [DEPTH];
  bit [31:0]   exp_rdat[DEPTH];
  bit [3:0]    exp_stb [DEPTH];
  bit          pend_v  [DEPTH];
  int          pend_a  [DEPTH];
  bit [15:0]   pend_d  [DEPTH];

  logic [63:0] rv_img = RV;
  logic [15:0] m_regs [NR];
  logic [63:0] m_pack;
  logic [31:0] m_rdata;
  int          m_err;

  always @(negedge Clk) begin
    if (Rst) begin
      for (int k = cyc; k < DEPTH; k++) begin
        exp_wd[k] = 1'b0; exp_we[k] = 1'b0; exp_rd[k] = 1'b0; exp_re[k] = 1'b0;
        exp_stb[k] = 4'd0; pend_v[k] = 1'b0;
      end
      for (int r = 0; r < NR; r++) m_regs[r] = rv_img[r*RW +: RW];
      m_err   = 0;
      m_rdata = 32'd0;
      chk("rst_regs",   regs_o, rv_img);
      chk("rst_strobe", 64'(wr_strobe_o), 64'd0);
      chk("rst_acks",   64'({VMERdDone, VMEWrDone, VMERdError, VMEWrError}), 64'd0);
      chk("rst_rdata",  64'(VMERdData), 64'd0);
      chk("rst_errcnt", 64'(err_cnt_o), 64'd0);
    end else begin
      if (pend_v[cyc]) m_regs[pend_a[cyc]] = pend_d[cyc];
      if (exp_rd[cyc]) m_rdata = exp_rdat[cyc];
      if (exp_re[cyc]) m_rdata = 32'd0;
      for (int r = 0; r < NR; r++) m_pack[r*RW +: RW] = m_regs[r];
      chk("wr_done",  64'(VMEWrDone),   64'(exp_wd[cyc]));
      chk("wr_error", 64'(VMEWrError),  64'(exp_we[cyc]));
      chk("rd_done",  64'(VMERdDone),   64'(exp_rd[cyc]));
      chk("rd_error", 64'(VMERdError),  64'(exp_re[cyc]));
      chk("strobe",   64'(wr_strobe_o), 64'(exp_stb[cyc]));
      chk("rd_data",  64'(VMERdData),   64'(m_rdata));
      chk("regs",     regs_o,           m_pack);
      chk("err_cnt",  64'(err_cnt_o),   64'(m_err));
      m_err = m_err + int'(exp_re[cyc]) + int'(exp_we[cyc]);
      if (m_err > 255) m_err = 255;
      if (VMEWrMem && cyc + 2 < DEPTH) begin
        if (int'(VMEAddr) < NR) begin
          pend_v[cyc+2] = 1'b1;
          pend_a[cyc+2] = int'(VMEAddr);
          pend_d[cyc+2] = VMEWrData[15:0];
          exp_wd[cyc+2] = 1'b1;
          exp_stb[cyc+2][int'(VMEAddr)] = 1'b1;
        end else begin
          exp_we[cyc+2] = 1'b1;
        end
      end
      if (VMERdMem && cyc + RD_LAT < DEPTH) begin
        if (int'(VMEAddr) < NR) begin
          exp_rd[cyc+RD_LAT]   = 1'b1;
          exp_rdat[cyc+RD_LAT] = {16'd0, m_regs[int'(VMEAddr)]};
        end else begin
          exp_re[cyc+RD_LAT] = 1'b1;
        end
      end
    end
  end

  // Latency and pulse bookkeeping used by the literal scenario checks.
  int         wr_req_c = 0, rd_req_c = 0, wr_lat = -1, rd_lat = -1;
  int         wr_done_cnt = 0, first_done_c = 0, last_done_c = 0, stb_cnt = 0;
  logic [3:0] stb_last = 4'd0;

  always @(negedge Clk) begin
    if (VMEWrDone || VMEWrError) wr_lat = cyc - wr_req_c;
    if (VMERdDone || VMERdError) rd_lat = cyc - rd_req_c;
    if (VMEWrDone) begin
      wr_done_cnt++;
      if (cyc - last_done_c > 1) first_done_c = cyc;
      last_done_c = cyc;
    end
    if (wr_strobe_o != 4'd0) begin
      stb_cnt++;
      stb_last = wr_strobe_o;
    end
  end

  task automatic drive(input logic rd, input logic wr, input int a, input logic [31:0] d);
    VMERdMem  = rd;
    VMEWrMem  = wr;
    VMEAddr   = AW'(a);
    VMEWrData = d;
    if (wr) wr_req_c = cyc;
    if (rd) rd_req_c = cyc;
  endtask

  task automatic step(input logic rd, input logic wr, input int a, input logic [31:0] d);
    @(posedge Clk);
    #1;
    drive(rd, wr, a, d);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 0, 32'd0);
  endtask

  int base_done, base_stb;

  initial begin
    drive(1'b0, 1'b0, 0, 32'd0);
    repeat (3) @(posedge Clk);
    #1 Rst = 1'b0;

    // Write then read register 2.
    base_stb = stb_cnt;
    step(1'b0, 1'b1, 2, 32'hDEADBEEF);
    idle(1);
    step(1'b1, 1'b0, 2, 32'd0);
    idle(4);
    chk("s1_wr_lat",  64'(wr_lat), 64'd2);
    chk("s1_rd_lat",  64'(rd_lat), 64'(RD_LAT));
    chk("s1_rdata",   64'(VMERdData), 64'h0000_BEEF);
    chk("s1_reg2",    64'(regs_o[47:32]), 64'h BEEF);
    chk("s1_stb",     64'(stb_last), 64'b0100);
    chk("s1_stb_cnt", 64'(stb_cnt - base_stb), 64'd1);

    // Unmapped read and write.
    step(1'b1, 1'b0, 7, 32'd0);
    idle(3);
    chk("s2_rdata0",  64'(VMERdData), 64'd0);
    chk("s2_errcnt1", 64'(err_cnt_o), 64'd1);
    step(1'b0, 1'b1, 7, 32'h1234_5678);
    idle(4);
    chk("s2_errcnt2", 64'(err_cnt_o), 64'd2);
    chk("s2_regs",    regs_o, 64'h4444_BEEF_0001_A5A5);
    step(1'b1, 1'b1, 9, 32'h0000_9999);
    idle(4);
    chk("s2_errcnt4", 64'(err_cnt_o), 64'd4);

    // Same-cycle read+write, then read at distance one, then a later read.
    step(1'b1, 1'b1, 1, 32'h0000_0055);
    step(1'b1, 1'b0, 1, 32'd0);
    idle(3);
    chk("s3_old", 64'(VMERdData), 64'h0001);
    step(1'b1, 1'b0, 1, 32'd0);
    idle(3);
    chk("s3_new", 64'(VMERdData), 64'h0055);

    // Back-to-back writes.
    base_done = wr_done_cnt;
    for (int a = 0; a < 4; a++) step(1'b0, 1'b1, a, 32'hC0DE_1000 + 32'(a));
    idle(4);
    chk("s4_done_cnt", 64'(wr_done_cnt - base_done), 64'd4);
    chk("s4_span",     64'(last_done_c - first_done_c), 64'd3);
    chk("s4_regs",     regs_o, 64'h1003_1002_1001_1000);

    // Reset the cycle after a write request; read in the first cycle after release.
    base_done = wr_done_cnt;
    step(1'b0, 1'b1, 0, 32'h0000_FFFF);
    @(posedge Clk);
    #1;
    Rst = 1'b1;
    drive(1'b0, 1'b0, 0, 32'd0);
    idle(2);
    @(posedge Clk);
    #1;
    Rst = 1'b0;
    drive(1'b1, 1'b0, 2, 32'd0);
    idle(4);
    chk("s5_no_done", 64'(wr_done_cnt - base_done), 64'd0);
    chk("s5_reg0",    64'(regs_o[15:0]), 64'h A5A5);
    chk("s5_rd_first", 64'(VMERdData), 64'h3333);

    // Saturating error counter.
    for (int i = 0; i < 300; i++) begin
      step(1'b1, 1'b0, (i % 3 == 0) ? 'h3FFFF : 4 + (i % 60), 32'd0);
    end
    idle(4);
    chk("s6_errcnt", 64'(err_cnt_o), 64'd255);
    chk("s6_rd_lat", 64'(rd_lat), 64'(RD_LAT));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
